// File: rtl/pipe_control.sv
// Registered decode plus multiply/divide start/stall sequencer between the F/D and D/X registers.
// Define PIPE_CTRL_EXC_EN to report multdiv exceptions and timeouts to $rstatus (r30).
module pipe_control #(
  parameter int unsigned OPW        = 5,
  parameter int unsigned ALUW       = 5,
  parameter int unsigned REGW       = 5,
  parameter int unsigned MD_TIMEOUT = 40
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            valid_in,
  input  logic            flush,
  input  logic [OPW-1:0]  opcode,
  input  logic [ALUW-1:0] aluop_in,
  input  logic [REGW-1:0] rd_in,
  input  logic            md_ready,
  input  logic            md_exception,
  output logic            stall,
  output logic            ctrl_mult,
  output logic            ctrl_div,
  output logic            valid_out,
  output logic [ALUW-1:0] aluop,
  output logic            aluInB,
  output logic            RWE,
  output logic            Dmem_WE,
  output logic            mem_to_reg,
  output logic            regfile_readB_rt_rd,
  output logic            is_branch,
  output logic            md_sel,
  output logic [REGW-1:0] rd_out,
  output logic            exc_out,
  output logic [1:0]      exc_code
);

  localparam int unsigned CntW = $clog2(MD_TIMEOUT);

  localparam logic [OPW-1:0]  OpRtype = OPW'(0);
  localparam logic [OPW-1:0]  OpBne   = OPW'(2);
  localparam logic [OPW-1:0]  OpAddi  = OPW'(5);
  localparam logic [OPW-1:0]  OpBlt   = OPW'(6);
  localparam logic [OPW-1:0]  OpSw    = OPW'(7);
  localparam logic [OPW-1:0]  OpLw    = OPW'(8);
  localparam logic [ALUW-1:0] AluSub  = ALUW'(1);
  localparam logic [ALUW-1:0] AluMul  = ALUW'(6);
  localparam logic [ALUW-1:0] AluDiv  = ALUW'(7);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  typedef struct packed {
    logic            valid;
    logic [ALUW-1:0] aluop;
    logic            alu_in_b;
    logic            rwe;
    logic            dmem_we;
    logic            mem_to_reg;
    logic            read_b_rd;
    logic            is_branch;
    logic            md_sel;
    logic [REGW-1:0] rd;
    logic            exc;
    logic [1:0]      exc_code;
  } ctrl_t;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            div_q, div_d;
  logic [REGW-1:0] rd_q, rd_d;
  ctrl_t           out_q, out_d;
  logic            is_md;

  assign is_md     = valid_in && (opcode == OpRtype) && (aluop_in == AluMul || aluop_in == AluDiv);
  // valid_in is only looked at in StIdle, so stall never depends on it elsewhere.
  assign stall     = (state_q != StIdle) || is_md;
  assign ctrl_mult = (state_q == StIssue) && !div_q;
  assign ctrl_div  = (state_q == StIssue) && div_q;

`ifndef PIPE_CTRL_EXC_EN
  logic unused_md_exception;
  assign unused_md_exception = md_exception;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    rd_d    = rd_q;
    out_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (is_md) begin
          div_d   = (aluop_in == AluDiv);
          rd_d    = rd_in;
          state_d = StIssue;
        end else if (valid_in) begin
          out_d.valid = 1'b1;
          unique case (opcode)
            OpRtype: begin
              out_d.aluop = aluop_in;
              out_d.rwe   = 1'b1;
              out_d.rd    = rd_in;
            end
            OpAddi: begin
              out_d.alu_in_b = 1'b1;
              out_d.rwe      = 1'b1;
              out_d.rd       = rd_in;
            end
            OpSw: begin
              out_d.alu_in_b  = 1'b1;
              out_d.dmem_we   = 1'b1;
              out_d.read_b_rd = 1'b1;
              out_d.rd        = rd_in;
            end
            OpLw: begin
              out_d.alu_in_b   = 1'b1;
              out_d.rwe        = 1'b1;
              out_d.mem_to_reg = 1'b1;
              out_d.read_b_rd  = 1'b1;
              out_d.rd         = rd_in;
            end
            OpBne, OpBlt: begin
              out_d.aluop     = AluSub;
              out_d.read_b_rd = 1'b1;
              out_d.is_branch = 1'b1;
              out_d.rd        = rd_in;
            end
            default: ;
          endcase
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (md_ready) begin
          state_d     = StIdle;
          out_d.valid = 1'b1;
          out_d.rwe   = 1'b1;
`ifdef PIPE_CTRL_EXC_EN
          if (md_exception) begin
            out_d.rd       = REGW'(30);
            out_d.exc      = 1'b1;
            out_d.exc_code = div_q ? 2'd2 : 2'd1;
          end else begin
            out_d.md_sel = 1'b1;
            out_d.rd     = rd_q;
          end
`else
          out_d.md_sel = 1'b1;
          out_d.rd     = rd_q;
`endif
        end else if (cnt_q == CntW'(MD_TIMEOUT - 1)) begin
          state_d     = StIdle;
          out_d.valid = 1'b1;
`ifdef PIPE_CTRL_EXC_EN
          out_d.rwe      = 1'b1;
          out_d.rd       = REGW'(30);
          out_d.exc      = 1'b1;
          out_d.exc_code = 2'd3;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      out_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      rd_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      rd_q    <= rd_d;
      out_q   <= out_d;
    end
  end

  assign valid_out           = out_q.valid;
  assign aluop               = out_q.aluop;
  assign aluInB              = out_q.alu_in_b;
  assign RWE                 = out_q.rwe;
  assign Dmem_WE             = out_q.dmem_we;
  assign mem_to_reg          = out_q.mem_to_reg;
  assign regfile_readB_rt_rd = out_q.read_b_rd;
  assign is_branch           = out_q.is_branch;
  assign md_sel              = out_q.md_sel;
  assign rd_out              = out_q.rd;
  assign exc_out             = out_q.exc;
  assign exc_code            = out_q.exc_code;

endmodule

// File: tb/tb_pipe_control.sv
// Self-checking bench for pipe_control: decode vector table, multdiv corner sequences,
// then randomized traffic against a cycle-age reference model.
module tb_pipe_control;
  localparam int unsigned TO = 8;

  logic       clock = 1'b0;
  logic       reset, valid_in, flush, md_ready, md_exception;
  logic [4:0] opcode, aluop_in, rd_in;
  logic       stall, ctrl_mult, ctrl_div, valid_out, aluInB, RWE, Dmem_WE, mem_to_reg;
  logic       regfile_readB_rt_rd, is_branch, md_sel, exc_out;
  logic [4:0] aluop, rd_out;
  logic [1:0] exc_code;

  pipe_control #(.OPW(5), .ALUW(5), .REGW(5), .MD_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .flush(flush), .opcode(opcode),
    .aluop_in(aluop_in), .rd_in(rd_in), .md_ready(md_ready), .md_exception(md_exception),
    .stall(stall), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .valid_out(valid_out),
    .aluop(aluop), .aluInB(aluInB), .RWE(RWE), .Dmem_WE(Dmem_WE), .mem_to_reg(mem_to_reg),
    .regfile_readB_rt_rd(regfile_readB_rt_rd), .is_branch(is_branch), .md_sel(md_sel),
    .rd_out(rd_out), .exc_out(exc_out), .exc_code(exc_code)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       v;
    logic [4:0] aluop;
    logic       alub, rwe, dwe, m2r, rdb, br, mds;
    logic [4:0] rd;
    logic       exc;
    logic [1:0] code;
  } outs_t;

  typedef struct {
    bit         rst, vld, fl;
    logic [4:0] op, alu, rd;
    outs_t      exp;
  } vec_t;

  outs_t act;
  assign act = {valid_out, aluop, aluInB, RWE, Dmem_WE, mem_to_reg, regfile_readB_rt_rd,
                is_branch, md_sel, rd_out, exc_out, exc_code};

  int    checks = 0, errors = 0;
  int    m_age = 0;
  logic  m_div = 1'b0;
  logic [4:0] m_rd = '0;
  outs_t m_out = '0;
  logic  s_stall, s_mult, s_div;

  function automatic outs_t mk(input logic v, input logic [4:0] alu, input logic alub, rwe, dwe,
                               m2r, rdb, br, mds, input logic [4:0] rd, input logic exc,
                               input logic [1:0] code);
    outs_t o;
    o = {v, alu, alub, rwe, dwe, m2r, rdb, br, mds, rd, exc, code};
    return o;
  endfunction

  function automatic outs_t decode(input logic [4:0] op, alu, rd);
    case (op)
      5'd0:       return mk(1, alu, 0, 1, 0, 0, 0, 0, 0, rd, 0, 0);
      5'd5:       return mk(1, 0, 1, 1, 0, 0, 0, 0, 0, rd, 0, 0);
      5'd7:       return mk(1, 0, 1, 0, 1, 0, 1, 0, 0, rd, 0, 0);
      5'd8:       return mk(1, 0, 1, 1, 0, 1, 1, 0, 0, rd, 0, 0);
      5'd2, 5'd6: return mk(1, 5'd1, 0, 0, 0, 0, 1, 1, 0, rd, 0, 0);
      default:    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endcase
  endfunction

  function automatic outs_t md_result(input logic is_div, exc, input logic [4:0] rd);
`ifdef PIPE_CTRL_EXC_EN
    if (exc) return mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 5'd30, 1, is_div ? 2'd2 : 2'd1);
`endif
    return mk(1, 0, 0, 1, 0, 0, 0, 0, 1, rd, 0, 0);
  endfunction

  function automatic outs_t timeout_out();
`ifdef PIPE_CTRL_EXC_EN
    return mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 5'd30, 1, 2'd3);
`else
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock: settle inputs, sample combinational outputs, clock, sample registered outputs.
  // m_age counts cycles since a multdiv was accepted (0 = none in flight).
  task automatic tick(input bit cmp);
    bit   md;
    logic e_stall, e_mult, e_div;
    md      = valid_in && opcode == 5'd0 && (aluop_in == 5'd6 || aluop_in == 5'd7);
    e_mult  = (m_age == 1) && !m_div;
    e_div   = (m_age == 1) && m_div;
    e_stall = (m_age != 0) || md;
    #3;
    s_stall = stall;
    s_mult  = ctrl_mult;
    s_div   = ctrl_div;
    if (cmp) begin
      check("stall", {31'd0, stall}, {31'd0, e_stall});
      check("ctrl_mult", {31'd0, ctrl_mult}, {31'd0, e_mult});
      check("ctrl_div", {31'd0, ctrl_div}, {31'd0, e_div});
    end
    if (reset) begin
      m_age = 0; m_rd = '0; m_div = 1'b0; m_out = '0;
    end else if (flush) begin
      m_age = 0; m_out = '0;
    end else if (m_age == 0) begin
      m_out = '0;
      if (md) begin
        m_age = 1; m_div = (aluop_in == 5'd7); m_rd = rd_in;
      end else if (valid_in) begin
        m_out = decode(opcode, aluop_in, rd_in);
      end
    end else if (m_age == 1) begin
      m_age = 2; m_out = '0;
    end else if (md_ready) begin
      m_age = 0; m_out = md_result(m_div, md_exception, m_rd);
    end else if (m_age == TO + 1) begin
      m_age = 0; m_out = timeout_out();
    end else begin
      m_age++; m_out = '0;
    end
    @(posedge clock);
    #1;
    if (cmp) check("outs_model", {11'd0, act}, {11'd0, m_out});
  endtask

  task automatic idle_in();
    reset = 0; valid_in = 0; flush = 0; md_ready = 0; md_exception = 0;
    opcode = 0; aluop_in = 0; rd_in = 0;
  endtask

  task automatic issue_md(input bit is_div, input logic [4:0] rd);
    idle_in();
    valid_in = 1; opcode = 5'd0; aluop_in = is_div ? 5'd7 : 5'd6; rd_in = rd;
  endtask

  vec_t vecs[12];
  int   n_stall, n_mult, n_div, n;
  outs_t exp_o;

  initial begin
    idle_in();
    reset = 1;
    tick(0);

    vecs[0]  = '{1, 1, 0, 5'd8, 5'd0, 5'd3, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{1, 1, 0, 5'd8, 5'd0, 5'd3, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[2]  = '{0, 1, 0, 5'd8, 5'd0, 5'd3, mk(1, 0, 1, 1, 0, 1, 1, 0, 0, 3, 0, 0)};
    vecs[3]  = '{0, 1, 0, 5'd5, 5'd9, 5'd4, mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 4, 0, 0)};
    vecs[4]  = '{0, 1, 0, 5'd7, 5'd0, 5'd5, mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 5, 0, 0)};
    vecs[5]  = '{0, 1, 0, 5'd2, 5'd0, 5'd6, mk(1, 1, 0, 0, 0, 0, 1, 1, 0, 6, 0, 0)};
    vecs[6]  = '{0, 1, 0, 5'd6, 5'd4, 5'd9, mk(1, 1, 0, 0, 0, 0, 1, 1, 0, 9, 0, 0)};
    vecs[7]  = '{0, 1, 0, 5'd0, 5'd2, 5'd10, mk(1, 2, 0, 1, 0, 0, 0, 0, 0, 10, 0, 0)};
    vecs[8]  = '{0, 1, 0, 5'd31, 5'd2, 5'd11, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[9]  = '{0, 0, 0, 5'd5, 5'd0, 5'd12, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[10] = '{0, 1, 1, 5'd5, 5'd0, 5'd13, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[11] = '{0, 1, 0, 5'd0, 5'd3, 5'd1, mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0)};

    for (int i = 0; i < 12; i++) begin
      idle_in();
      reset = vecs[i].rst; valid_in = vecs[i].vld; flush = vecs[i].fl;
      opcode = vecs[i].op; aluop_in = vecs[i].alu; rd_in = vecs[i].rd;
      tick(0);
      check($sformatf("vec%0d_stall", i), {31'd0, s_stall}, 32'd0);
      check($sformatf("vec%0d_outs", i), {11'd0, act}, {11'd0, vecs[i].exp});
    end

    // mul rd=7, md_ready five cycles after ctrl_mult; other valid traffic must be ignored.
    issue_md(0, 5'd7);
    tick(1);
    n_stall = s_stall; n_mult = s_mult;
    for (int k = 1; k <= 6; k++) begin
      idle_in();
      valid_in = 1; opcode = 5'd5; rd_in = 5'd2;
      md_ready = (k == 6);
      tick(1);
      n_stall += s_stall; n_mult += s_mult;
    end
    check("mul_stall_cycles", n_stall, 7);
    check("mul_pulse_cycles", n_mult, 1);
    check("mul_result", {11'd0, act}, {11'd0, mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 7, 0, 0)});
    idle_in();
    tick(1);
    check("mul_stall_released", {31'd0, s_stall}, 32'd0);

    // div rd=12 with exception on earliest md_ready.
    issue_md(1, 5'd12);
    tick(1);
    n_div = 0;
    idle_in();
    tick(1);
    n_div += s_div;
    md_ready = 1; md_exception = 1;
    tick(1);
    n_div += s_div;
    check("div_pulse_cycles", n_div, 1);
`ifdef PIPE_CTRL_EXC_EN
    exp_o = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 5'd30, 1, 2'd2);
`else
    exp_o = mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 5'd12, 0, 0);
`endif
    check("div_exception", {11'd0, act}, {11'd0, exp_o});

    // mul never answered: abort after the timeout window.
    issue_md(0, 5'd3);
    n_stall = 0; n = 0;
    while (n < 40) begin
      tick(1);
      if (n == 0) idle_in();
      n_stall += s_stall; n++;
      if (act[20]) break;
    end
    check("timeout_within_bound", {31'd0, act[20]}, 32'd1);
    check("timeout_stall_cycles", n_stall, TO + 2);
    check("timeout_outs", {11'd0, act}, {11'd0, timeout_out()});
    idle_in();
    tick(1);
    check("timeout_stall_released", {31'd0, s_stall}, 32'd0);

    // flush together with md_ready in WAIT discards the result.
    issue_md(0, 5'd8);
    tick(1);
    idle_in();
    tick(1);
    md_ready = 1; flush = 1;
    tick(1);
    check("flush_md_outs", {11'd0, act}, 32'd0);
    idle_in();
    valid_in = 1; opcode = 5'd5; rd_in = 5'd14;
    tick(1);
    check("flush_then_idle_stall", {31'd0, s_stall}, 32'd0);
    check("flush_then_addi", {11'd0, act}, {11'd0, mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 14, 0, 0)});

    // Reset mid-WAIT, late md_ready ignored.
    issue_md(1, 5'd9);
    tick(1);
    idle_in();
    tick(1);
    reset = 1;
    tick(1);
    idle_in();
    md_ready = 1;
    tick(1);
    check("rst_wait_stall", {31'd0, s_stall}, 32'd0);
    check("rst_wait_pulse", {30'd0, s_mult, s_div}, 32'd0);
    check("rst_wait_late_ready", {11'd0, act}, 32'd0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] ops [10];
      ops = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd7, 5'd8, 5'd2, 5'd6, 5'd31, 5'd3};
      reset        = ($urandom_range(0, 149) == 0);
      valid_in     = ($urandom_range(0, 9) < 8);
      flush        = ($urandom_range(0, 24) == 0);
      md_ready     = ($urandom_range(0, 4) == 0);
      md_exception = $urandom_range(0, 1) == 1;
      opcode       = ops[$urandom_range(0, 9)];
      aluop_in     = 5'($urandom_range(0, 7));
      rd_in        = 5'($urandom_range(0, 31));
      tick(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_control.md
# pipe_control

Registered, parametrised successor to the processor's combinational decoder. Sits between the F/D and D/X pipeline registers: decodes opcode/ALU-op into datapath controls one cycle after issue and sequences multi-cycle multiply/divide instructions through the multdiv unit with a stall/handshake FSM. Adds branch decode, flush, a watchdog timeout and optional exception reporting to `$rstatus`.

## Interface
Parameters:
- `OPW`, 5: opcode width.
- `ALUW`, 5: ALU-op width.
- `REGW`, 5: register-index width.
- `MD_TIMEOUT`, 40: maximum cycles to wait for `md_ready` before aborting; must be ≥2.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock, sync active-high reset, as already decided.
- `valid_in`  in  1  instruction on `opcode`/`aluop_in`/`rd_in` is valid.
- `flush`  in  1  kill the in-flight/decoded instruction (branch taken).
- `opcode`  in  OPW  instruction opcode.
- `aluop_in`  in  ALUW  R-type ALU-op field.
- `rd_in`  in  REGW  destination register.
- `md_ready`  in  1  multdiv result valid (one-cycle pulse).
- `md_exception`  in  1  multdiv overflow/div-by-zero, qualified by `md_ready`.
- `stall`  out  1  upstream must hold F/D contents.
- `ctrl_mult`, `ctrl_div`  out  1  one-cycle start pulses to multdiv.
- `valid_out`  out  1  D/X controls below are meaningful.
- `aluop`  out  ALUW  ALU operation.
- `aluInB`, `RWE`, `Dmem_WE`, `mem_to_reg`, `regfile_readB_rt_rd`, `is_branch`, `md_sel`  out  1  datapath controls; `md_sel` selects multdiv result for writeback.
- `rd_out`  out  REGW  writeback register.
- `exc_out`  out  1  exception status write this cycle.
- `exc_code`  out  2  1=mul, 2=div, 3=timeout, 0=none.

## Operation
- Decode (all outputs zero when not valid): `00000` R-type: `aluop=aluop_in`, RWE. `00101` addi: `aluop=0`, aluInB, RWE. `00111` sw: aluInB, Dmem_WE, readB_rd. `01000` lw: aluInB, RWE, mem_to_reg, readB_rd. `00010` bne and `00110` blt: `aluop=00001` (subtract), readB_rd, is_branch. Any other opcode: bubble (`valid_out=1`, all controls 0).
- Multdiv = opcode `00000` with `aluop_in` `00110` (mul) or `00111` (div).
- FSM states IDLE, ISSUE, WAIT.
  - IDLE: valid non-multdiv → register controls, stay. Valid multdiv → latch op and `rd_in`, go ISSUE, `valid_out=0`.
  - ISSUE: pulse `ctrl_mult` or `ctrl_div` for exactly one cycle, clear counter, go WAIT.
  - WAIT: counter increments each cycle. `md_ready` → `valid_out=1`, `RWE=1`, `md_sel=1`, `rd_out`=latched rd, go IDLE. Counter reaching `MD_TIMEOUT-1` without `md_ready` → abort (see Configuration), go IDLE.
- `stall=1` in ISSUE and WAIT and in the IDLE cycle a multdiv is accepted (combinational on inputs). While `stall=1`, `valid_in` is ignored.
- `flush`: next edge forces IDLE, `valid_out=0`, no start pulse; priority below `reset`, above everything else. `flush` with `md_ready` in the same cycle → result discarded, no exception.
- Counter width `$clog2(MD_TIMEOUT)`; saturates, never wraps.

## Timing
- Reset: all outputs 0, FSM IDLE, counter 0, latched rd 0.
- Non-multdiv latency: 1 cycle, throughput 1/cycle, `stall` never asserted.
- Multdiv: accept at cycle T, `ctrl_*` high at T+1, earliest `md_ready` at T+2, controls valid the edge after `md_ready`. Stall released the cycle after `md_ready` is sampled.
- Reset mid-WAIT: next cycle idle, no start pulse, late `md_ready` ignored.
- `md_ready` while IDLE/ISSUE: ignored.

## Configuration
- `PIPE_CTRL_EXC_EN` defined: `md_exception` with `md_ready` → result write suppressed, instead `RWE=1`, `rd_out=30`, `exc_out=1`, `exc_code`=1 (mul) or 2 (div), `md_sel=0`. Timeout → same with `exc_code=3`.
- Not defined: `exc_out`/`exc_code` tied 0; exception results written normally to `rd`; timeout yields a bubble (`valid_out=1`, controls 0).

## Test plan
- Reset held 2 cycles with `valid_in=1`, `opcode=01000` → all outputs 0; after release, next edge `RWE=mem_to_reg=aluInB=readB_rd=1`.
- Back-to-back addi, sw, bne → 1-cycle latency each; bne gives `aluop=00001`, `is_branch=1`; `stall` stays 0.
- mul rd=7, `md_ready` 5 cycles after `ctrl_mult` → `ctrl_mult` one cycle, `stall` high 7 cycles, then `RWE=md_sel=1`, `rd_out=7`.
- div with `md_exception` on `md_ready` (EXC_EN defined) → `rd_out=30`, `exc_out=1`, `exc_code=2`; undefined → `rd_out`=original rd, `exc_out=0`.
- mul with no `md_ready`, `MD_TIMEOUT=8` → abort 8 cycles after ISSUE, `exc_code=3` (EXC_EN defined), `stall` drops.
- `flush` in WAIT simultaneous with `md_ready` → `valid_out=0`, no write, FSM IDLE next cycle.
